// File: rtl/prime_pair_gen_pkg.sv
`default_nettype none
//==============================================================================
// Package : prime_pkg
// Brief   : Shared state encoding, force-bit mask and parameter legality check.
// Rev     : 1.0
//==============================================================================
package prime_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FILL       = 3'd1,
        ST_TEST_START = 3'd2,
        ST_TEST_WAIT  = 3'd3,
        ST_EMIT       = 3'd4,
        ST_FAIL       = 3'd5
    } state_e;

    localparam int MAX_WORDSIZE = 4096;
    localparam logic [MAX_WORDSIZE-1:0] C_ONE = {{(MAX_WORDSIZE-1){1'b0}}, 1'b1};

    // Top two bits keep the product of two primes at full key length; bit 0 keeps it odd.
    function automatic logic [MAX_WORDSIZE-1:0] mask(input int wordsize);
        return (C_ONE << (wordsize - 1)) | (C_ONE << (wordsize - 2)) | C_ONE;
    endfunction

    function automatic bit params_ok(input int wordsize, input int rand_w, input int num_primes);
        return (rand_w > 0) && (wordsize % rand_w == 0) && (wordsize >= 2 * rand_w) &&
               (wordsize <= MAX_WORDSIZE) && (num_primes >= 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prime_pair_gen_if.sv
`default_nettype none
//==============================================================================
// Interface : prime_pair_gen_if
// Brief     : Control, RNG, tester and prime-output signals of prime_pair_gen.
// Rev       : 1.0
//==============================================================================
interface prime_pair_gen_if #(
    parameter int WORDSIZE   = 256,
    parameter int RAND_W     = 16,
    parameter int NUM_PRIMES = 2,
    parameter int MAX_TRIES  = 1024,
    parameter int ACC_W      = 2 * WORDSIZE,
    parameter int TRY_W      = $clog2(MAX_TRIES + 1),
    parameter int IDX_W      = $clog2(NUM_PRIMES) + 1
);
    logic                start;
    logic [ACC_W-1:0]    accuracy;
    logic [RAND_W-1:0]   rand_in;
    logic                rand_valid;
    logic                rand_req;
    logic [WORDSIZE-1:0] tst_cand;
    logic [ACC_W-1:0]    tst_acc;
    logic                tst_start;
    logic                tst_finish;
    logic                tst_prime;
    logic [WORDSIZE-1:0] prime_out;
    logic [IDX_W-1:0]    prime_idx;
    logic                prime_valid;
    logic                prime_ready;
    logic [TRY_W-1:0]    tries;
    logic                busy;
    logic                done;
    logic                fail;

    modport master (
        input  start, accuracy, rand_in, rand_valid, tst_finish, tst_prime, prime_ready,
        output rand_req, tst_cand, tst_acc, tst_start, prime_out, prime_idx, prime_valid,
               tries, busy, done, fail
    );

    modport slave (
        output start, accuracy, rand_in, rand_valid, tst_finish, tst_prime, prime_ready,
        input  rand_req, tst_cand, tst_acc, tst_start, prime_out, prime_idx, prime_valid,
               tries, busy, done, fail
    );
endinterface
`default_nettype wire

// File: rtl/prime_pair_gen_cand_assembler.sv
`default_nettype none
//==============================================================================
// Module : cand_assembler
// Brief  : Collects RAND_W words LSW-first into a candidate and forces mask bits.
// Rev    : 1.0
//==============================================================================
module cand_assembler
    import prime_pkg::*;
#(
    parameter int WORDSIZE = 256,
    parameter int RAND_W   = 16
) (
    input  wire                 clk,
    input  wire                 reset,
    input  wire                 load,
    input  wire  [RAND_W-1:0]   word_in,
    output logic                full,
    output logic [WORDSIZE-1:0] cand
);
    localparam int NWORDS = WORDSIZE / RAND_W;
    localparam int CNT_W  = $clog2(NWORDS);
    localparam logic [MAX_WORDSIZE-1:0] C_MASK_FULL = mask(WORDSIZE);
    localparam logic [WORDSIZE-1:0]     C_MASK      = C_MASK_FULL[WORDSIZE-1:0];

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORDSIZE-1:0] cand_q, cand_d;

    // Combinational so the FSM can leave FILL on the very cycle the last word lands.
    assign full = load && (cnt_q == CNT_W'(NWORDS - 1));
    assign cand = cand_q;

    always_comb begin
        cnt_d  = cnt_q;
        cand_d = cand_q;
        if (load) begin
            for (int k = 0; k < NWORDS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    cand_d[k*RAND_W +: RAND_W] = word_in;
                end
            end
            if (full) begin
                cand_d = cand_d | C_MASK;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            cand_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            cand_q <= cand_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/prime_pair_gen.sv
`default_nettype none
//==============================================================================
// Module : prime_pair_gen
// Brief  : Builds random candidates, retries composites, emits NUM_PRIMES primes.
// Rev    : 1.0
//==============================================================================
module prime_pair_gen
    import prime_pkg::*;
#(
    parameter int WORDSIZE   = 256,
    parameter int RAND_W     = 16,
    parameter int NUM_PRIMES = 2,
    parameter int MAX_TRIES  = 1024,
    parameter int ACC_W      = 2 * WORDSIZE,
    parameter int TRY_W      = $clog2(MAX_TRIES + 1)
) (
    input  wire              clk,
    input  wire              reset,
    prime_pair_gen_if.master bus
);
    localparam int IDX_W = $clog2(NUM_PRIMES) + 1;

    if (!params_ok(WORDSIZE, RAND_W, NUM_PRIMES)) begin : g_param_check
        $error("prime_pair_gen: illegal WORDSIZE/RAND_W/NUM_PRIMES combination");
    end

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TRY_W-1:0]    tries_q, tries_d;
    logic                fail_q, fail_d;
    logic                done_q, done_d;
    logic [WORDSIZE-1:0] prime_q, prime_d;
    logic [WORDSIZE-1:0] prev_q, prev_d;

    logic                load, full;
    logic [WORDSIZE-1:0] cand;
    logic                rand_req, tst_start, prime_valid, busy;
    logic                dup, accept, last_try, last_prime;

    cand_assembler #(
        .WORDSIZE (WORDSIZE),
        .RAND_W   (RAND_W)
    ) u_cand_assembler (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .word_in (bus.rand_in),
        .full    (full),
        .cand    (cand)
    );

    // A repeat of the previous prime would give p == q, so it is treated as composite.
    assign dup        = (idx_q != '0) && (cand == prev_q);
    assign accept     = bus.tst_prime && !dup;
    assign last_try   = (tries_q == TRY_W'(MAX_TRIES - 1));
    assign last_prime = (idx_q == IDX_W'(NUM_PRIMES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:       if (bus.start) state_d = ST_FILL;
            ST_FILL:       if (full) state_d = ST_TEST_START;
            ST_TEST_START: state_d = ST_TEST_WAIT;
            ST_TEST_WAIT: begin
                if (bus.tst_finish) begin
                    if (accept)        state_d = ST_EMIT;
                    else if (last_try) state_d = ST_FAIL;
                    else               state_d = ST_FILL;
                end
            end
            ST_EMIT:       if (bus.prime_ready) state_d = last_prime ? ST_IDLE : ST_FILL;
            ST_FAIL:       state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rand_req    = (state_q == ST_FILL);
        tst_start   = (state_q == ST_TEST_START);
        prime_valid = (state_q == ST_EMIT);
        busy        = (state_q != ST_IDLE);
    end

    assign load = rand_req && bus.rand_valid;

    always_comb begin
        acc_d   = acc_q;
        idx_d   = idx_q;
        tries_d = tries_q;
        fail_d  = fail_q;
        done_d  = 1'b0;
        prime_d = prime_q;
        prev_d  = prev_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.accuracy;
                    idx_d   = '0;
                    tries_d = '0;
                    fail_d  = 1'b0;
                end
            end
            ST_TEST_WAIT: begin
                if (bus.tst_finish) begin
                    if (accept) begin
                        prime_d = cand;
                    end else if (last_try) begin
                        tries_d = TRY_W'(MAX_TRIES);
                        fail_d  = 1'b1;
                    end else begin
                        tries_d = tries_q + 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                if (bus.prime_ready) begin
                    prev_d = prime_q;
                    if (last_prime) begin
                        done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        tries_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            idx_q   <= '0;
            tries_q <= '0;
            fail_q  <= 1'b0;
            done_q  <= 1'b0;
            prime_q <= '0;
            prev_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            tries_q <= tries_d;
            fail_q  <= fail_d;
            done_q  <= done_d;
            prime_q <= prime_d;
            prev_q  <= prev_d;
        end
    end

    assign bus.rand_req    = rand_req;
    assign bus.tst_cand    = cand;
    assign bus.tst_acc     = acc_q;
    assign bus.tst_start   = tst_start;
    assign bus.prime_out   = prime_q;
    assign bus.prime_idx   = idx_q;
    assign bus.prime_valid = prime_valid;
    assign bus.tries       = tries_q;
    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.fail        = fail_q;
endmodule
`default_nettype wire

// File: doc/prime_pair_gen.md
# prime_pair_gen

Parametrised successor to the single-candidate key generator. It assembles WORDSIZE-bit candidates from a stream of RAND_W-bit random words and hands each one to an external primality tester (miller_rabin) over a start/finish handshake. It retries composites up to a bounded count and emits NUM_PRIMES accepted primes on a valid/ready output port. It sits between rand127 and the RSA key assembly logic.

## Interface
- WORDSIZE, 256: candidate width in bits; must be a multiple of RAND_W and at least 2*RAND_W.
- RAND_W, 16: random word width.
- NUM_PRIMES, 2: primes produced per start request, at least 1.
- MAX_TRIES, 1024: composites tolerated per prime before failing.
- ACC_W, 2*WORDSIZE: accuracy field width, passed through to the tester.
- TRY_W, $clog2(MAX_TRIES+1): try counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- accuracy  in  ACC_W  latched on an accepted start.
- rand_in  in  RAND_W  random word.
- rand_valid  in  1  rand_in is valid this cycle.
- rand_req  out  1  block consumes rand_in when rand_req && rand_valid.
- tst_cand  out  WORDSIZE  candidate to the tester; stable from TEST_START until finish.
- tst_acc  out  ACC_W  latched accuracy.
- tst_start  out  1  one-cycle pulse; drives the tester's reset/start.
- tst_finish  in  1  tester result strobe.
- tst_prime  in  1  tester verdict, valid with tst_finish.
- prime_out  out  WORDSIZE  accepted prime.
- prime_idx  out  $clog2(NUM_PRIMES)+1  index of prime_out, starting at 0.
- prime_valid  out  1  prime_out and prime_idx are valid.
- prime_ready  in  1  consumer accepts.
- tries  out  TRY_W  composites rejected for the current prime.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last prime is accepted.
- fail  out  1  sticky until the next accepted start; retry budget exhausted.

## Operation
- States: IDLE, FILL, TEST_START, TEST_WAIT, EMIT, FAIL.
- IDLE:
  - On start: latch accuracy, clear prime_idx, tries and fail, then go to FILL.
  - start is ignored in every other state.
- FILL:
  - rand_req = 1.
  - Each handshake writes rand_in into word slot k, bits [(k+1)*RAND_W-1 : k*RAND_W], with k counting from 0 (least-significant word first).
  - After WORDSIZE/RAND_W words, force bits WORDSIZE-1, WORDSIZE-2 and 0 to 1, then go to TEST_START.
- TEST_START: tst_start = 1 for exactly one cycle, then go to TEST_WAIT.
- TEST_WAIT:
  - tst_finish && tst_prime && candidate != previous accepted prime (check applies only when prime_idx > 0) -> EMIT.
  - Otherwise on tst_finish:
    - tries+1 == MAX_TRIES -> set tries = MAX_TRIES and go to FAIL.
    - Else tries+1 and back to FILL.
  - A prime equal to the previous accepted prime counts as a composite.
- EMIT:
  - prime_valid = 1 with prime_out held.
  - On prime_ready: if prime_idx == NUM_PRIMES-1, pulse done and go to IDLE; else prime_idx+1, tries = 0, go to FILL.
- FAIL: fail = 1, then go to IDLE in the next cycle. fail stays high until the next accepted start.
- tst_finish outside TEST_WAIT is ignored.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0, including tst_cand, prime_out, prime_idx, tries and fail.
  - Word counter 0; previous-prime register 0.
- Reset asserted mid-operation aborts immediately; no done or prime_valid follows.
- With rand_valid held high, FILL lasts exactly WORDSIZE/RAND_W cycles.
- TEST_START follows the last word by 1 cycle; tst_start is 1 cycle wide.
- EMIT is entered the cycle after tst_finish. prime_valid rises one cycle after that finish.
- prime_valid must not drop, and prime_out must not change, until prime_ready is seen.
- done rises in the cycle after the final prime_ready handshake.
- A rand_valid gap stalls FILL without losing words.

## Structure
- Shared package prime_pkg holds:
  - the state enum;
  - the force-bit mask constant function mask(WORDSIZE);
  - the parameter legality checks (WORDSIZE % RAND_W == 0, NUM_PRIMES >= 1).
- One sub-module, cand_assembler: word counter plus shift-in register plus force-bit OR. It exposes load, word_in, full and cand.
- The FSM, try counter, previous-prime register and output holding stay in prime_pair_gen.
- Tester and RNG stay external. Top-level integration wires rand127 and miller_rabin.

## Test plan
Bench configuration: WORDSIZE=32, RAND_W=16, NUM_PRIMES=2, MAX_TRIES=4.
- Assembly: start; rand words 0x1234 then 0x0008 -> tst_cand = 0xC0081235, with tst_start one cycle after the 2nd word.
- Retry: first verdict composite, second prime -> tries reads 1 during the second test; prime_valid with prime_idx = 0; tries = 0 after the handshake.
- Duplicate rejection: second prime is identical to the first, e.g. 0xC0000005 twice -> tries increments, FILL restarts, no emit.
- Fail: four composites for prime 0 -> fail = 1 and tries = 4; back in IDLE; no done; next start clears fail.
- Backpressure: prime_ready held low for 10 cycles in EMIT -> prime_out stable and prime_valid high throughout; done one cycle after the second handshake.
- Async reset: assert reset during TEST_WAIT -> all outputs 0 immediately; a late tst_finish is ignored; a fresh start works normally.
